eth_rx_parser: RTL and testbench
================================

ETH_RX_PARSER -- requirements
Module: eth_rx_parser

Interface
REQ-001 Parameter DROP_CNT_W, default 16, width of saturating drop counter.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_self_mac  input  48  station MAC; i_self_ip  input  32  station IPv4 address; both quasi-static.
REQ-005 i_rx_data  input  32  frame word, big-endian; word0 = {16'h0, dst_mac[47:32]}, word1 = dst_mac[31:0], word2 = src_mac[47:16], word3 = {src_mac[15:0], ethertype}.
REQ-006 i_rx_sop, i_rx_eop, i_rx_vld  input  1 each  start/end of frame, word valid; o_rx_rdy  output  1  ready.
REQ-007 o_arp_req  output  1  one-cycle pulse, ARP request for i_self_ip; o_arp_sha  output  48; o_arp_spa  output  32.
REQ-008 o_ping_req  output  1  one-cycle pulse, ICMP echo request; o_icmp_id, o_icmp_seq  output  16 each.
REQ-009 o_udp_vld  output  1  one-cycle pulse, UDP datagram header; o_udp_src_port, o_udp_dst_port, o_udp_len  output  16 each.
REQ-010 o_peer_mac  output  48, o_peer_ip  output  32  source of last reported frame (o_peer_ip = spa for ARP).
REQ-011 o_drop_cnt  output  DROP_CNT_W  count of discarded frames, saturating at all-ones.

Function
REQ-012 A word SHALL be accepted only in a cycle with i_rx_vld & o_rx_rdy; vld gaps SHALL stall parsing without state change.
REQ-013 o_rx_rdy SHALL be 1 in every state except REPORT, where it SHALL be 0 for exactly one cycle.
REQ-014 States: IDLE, HDR (words 0-3), ARP (words 4-10), IP (words 4-8), L4 (words 9-10), DRAIN, REPORT.
REQ-015 IDLE: accepted words without sop SHALL be ignored; accepted sop word SHALL be word0, move to HDR, word counter = 1.
REQ-016 Word counter SHALL be 4 bits, incremented per accepted word, saturating at 11.
REQ-017 Word1 check: dst_mac SHALL equal i_self_mac or 48'hFFFFFFFFFFFF, else mark frame dropped and go DRAIN.
REQ-018 Word3: ethertype 16'h0806 -> ARP, 16'h0800 -> IP, other -> DRAIN with drop.
REQ-019 ARP: word4 SHALL equal 32'h00010800, word5 32'h06040001, word10 (tpa) i_self_ip; sha/spa captured from words 6-8; any mismatch -> DRAIN with drop.
REQ-020 IP: word4[31:24] SHALL be 8'h45; word6[23:16] protocol 8'h01 (ICMP) or 8'h11 (UDP); word7 src_ip captured; word8 SHALL equal i_self_ip; mismatch -> DRAIN with drop.
REQ-021 ICMP: word9[31:24] SHALL be 8'h08, word10 = {id, seq}; UDP: word9 = {src_port, dst_port}, word10[31:16] = len.
REQ-022 After word10 with classification valid, remaining words SHALL be consumed in DRAIN with classification held until eop.
REQ-023 Accepted eop on a valid, fully classified frame SHALL enter REPORT; next cycle outputs are updated and exactly one of o_arp_req/o_ping_req/o_udp_vld pulses (latency 1 cycle from eop acceptance).
REQ-024 Data outputs SHALL hold their values until the next REPORT.
REQ-025 eop before word10 accepted SHALL drop the frame (o_drop_cnt +1, no pulse) and return to IDLE.
REQ-026 sop accepted in any state other than IDLE SHALL abort the current frame (o_drop_cnt +1) and restart at HDR with that word as word0.
REQ-027 sop and eop on the same word SHALL count as a dropped frame.
REQ-028 Every dropped frame SHALL increment o_drop_cnt exactly once, at its eop or abort.
REQ-029 Checksums SHALL NOT be verified.

Reset
REQ-030 rst SHALL force IDLE, o_rx_rdy = 1, all pulses 0, all data outputs and o_drop_cnt 0, regardless of frame in progress.
REQ-031 A frame interrupted by reset SHALL produce no pulse and no drop count; parsing resumes at next sop.

Verification
REQ-032 Broadcast ARP request, sha 48'h3CF011B2523C, spa 192.168.1.46, tpa = i_self_ip 10.0.0.20, eop on word10 -> o_arp_req pulse 1 cycle after eop, o_arp_sha = 48'h3CF011B2523C, o_arp_spa = 32'hC0A8012E.
REQ-033 Ping frame to 00:22:36:EC:04:01 / 10.0.0.20, 25 words, id 16'h1486 seq 16'h45C1 -> o_ping_req pulse, o_peer_ip = 32'h0A000016, o_icmp_id = 16'h1486, o_icmp_seq = 16'h45C1.
REQ-034 UDP frame, word9 32'h11225152, word10 32'h008814C3, 43 words, random vld gaps -> o_udp_vld pulse, ports 16'h1122/16'h5152, o_udp_len = 16'h0088.
REQ-035 ARP frame with eop on word7 -> no pulse, o_drop_cnt 0 -> 1; following valid ARP frame reports normally.
REQ-036 New sop at word5 of a ping frame followed by full ARP frame -> o_drop_cnt +1, single o_arp_req pulse.
REQ-037 rst asserted mid-UDP frame -> all outputs 0, no pulse; next valid frame reported.

Source files
------------

// File: rtl/eth_rx_parser.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_parser
//  Description : Receive-side Ethernet frame classifier. Walks the first
//                eleven 32-bit words of each frame, filters on destination
//                MAC/IP and reports ARP requests, ICMP echo requests and UDP
//                datagram headers. Rejected frames bump a saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_parser #(
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [47:0]           i_self_mac,
  input  logic [31:0]           i_self_ip,
  input  logic [31:0]           i_rx_data,
  input  logic                  i_rx_sop,
  input  logic                  i_rx_eop,
  input  logic                  i_rx_vld,
  output logic                  o_rx_rdy,
  output logic                  o_arp_req,
  output logic [47:0]           o_arp_sha,
  output logic [31:0]           o_arp_spa,
  output logic                  o_ping_req,
  output logic [15:0]           o_icmp_id,
  output logic [15:0]           o_icmp_seq,
  output logic                  o_udp_vld,
  output logic [15:0]           o_udp_src_port,
  output logic [15:0]           o_udp_dst_port,
  output logic [15:0]           o_udp_len,
  output logic [47:0]           o_peer_mac,
  output logic [31:0]           o_peer_ip,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_ARP    = 3'd2,
    S_IP     = 3'd3,
    S_L4     = 3'd4,
    S_DRAIN  = 3'd5,
    S_REPORT = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  state_t      w_step;
  logic [3:0]  r_cnt;          // index of the word about to be accepted
  logic        r_drop;         // frame already rejected, waiting for eop
  logic [15:0] r_dst_hi;
  logic [47:0] r_src_mac;
  logic        r_is_arp;
  logic        r_is_udp;
  logic [47:0] r_sha;
  logic [31:0] r_spa;
  logic [31:0] r_src_ip;
  logic [31:0] r_w9;
  logic [31:0] r_w10;

  logic        w_acc;
  logic        w_in_frame;
  logic        w_dst_ok;
  logic        w_bad;
  logic        w_done;
  logic        w_report;
  logic        w_restart;
  logic        w_mark_drop;
  logic [1:0]  w_drop_inc;
  logic [31:0] w_w10;
  logic [DROP_CNT_W:0] w_drop_sum;

  assign o_rx_rdy   = (r_state != S_REPORT);
  assign w_acc      = i_rx_vld & o_rx_rdy;
  assign w_in_frame = (r_state != S_IDLE) && (r_state != S_REPORT);
  assign w_dst_ok   = ({r_dst_hi, i_rx_data} == i_self_mac) ||
                      ({r_dst_hi, i_rx_data} == 48'hFFFF_FFFF_FFFF);
  // Word10 is still on the bus when eop arrives with it; otherwise it was stored.
  assign w_w10      = (r_state == S_DRAIN) ? r_w10 : i_rx_data;
  assign w_drop_sum = {1'b0, o_drop_cnt} + {{(DROP_CNT_W-1){1'b0}}, w_drop_inc};

  // Per-word field check for the current parse position and the state it leads to.
  always_comb begin
    w_bad  = 1'b0;
    w_done = 1'b0;
    w_step = r_state;
    case (r_state)
      S_HDR: begin
        case (r_cnt)
          4'd1: w_bad = !w_dst_ok;
          4'd3: begin
            if (i_rx_data[15:0] == 16'h0806)      w_step = S_ARP;
            else if (i_rx_data[15:0] == 16'h0800) w_step = S_IP;
            else                                  w_bad  = 1'b1;
          end
          default: ;
        endcase
      end
      S_ARP: begin
        case (r_cnt)
          4'd4:  w_bad = (i_rx_data != 32'h0001_0800);
          4'd5:  w_bad = (i_rx_data != 32'h0604_0001);
          4'd10: begin
            if (i_rx_data != i_self_ip) begin
              w_bad = 1'b1;
            end else begin
              w_done = 1'b1;
              w_step = S_DRAIN;
            end
          end
          default: ;
        endcase
      end
      S_IP: begin
        case (r_cnt)
          4'd4: w_bad = (i_rx_data[31:24] != 8'h45);
          4'd6: w_bad = (i_rx_data[23:16] != 8'h01) && (i_rx_data[23:16] != 8'h11);
          4'd8: begin
            if (i_rx_data != i_self_ip) w_bad  = 1'b1;
            else                        w_step = S_L4;
          end
          default: ;
        endcase
      end
      S_L4: begin
        case (r_cnt)
          4'd9:  w_bad = !r_is_udp && (i_rx_data[31:24] != 8'h08);
          4'd10: begin
            w_done = 1'b1;
            w_step = S_DRAIN;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Next-state, drop accounting and report decision for each accepted word.
  always_comb begin
    w_next      = r_state;
    w_report    = 1'b0;
    w_restart   = 1'b0;
    w_mark_drop = 1'b0;
    w_drop_inc  = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (w_acc && i_rx_sop) begin
          if (i_rx_eop) begin
            w_drop_inc = 2'd1;
          end else begin
            w_next    = S_HDR;
            w_restart = 1'b1;
          end
        end
      end
      S_REPORT: w_next = S_IDLE;
      default: begin
        if (w_acc) begin
          if (i_rx_sop) begin
            // Abort the frame in flight; a one-word sop+eop frame is a drop too.
            if (i_rx_eop) begin
              w_drop_inc = 2'd2;
              w_next     = S_IDLE;
            end else begin
              w_drop_inc = 2'd1;
              w_next     = S_HDR;
              w_restart  = 1'b1;
            end
          end else if (i_rx_eop) begin
            if (w_done || ((r_state == S_DRAIN) && !r_drop)) begin
              w_report = 1'b1;
              w_next   = S_REPORT;
            end else begin
              w_drop_inc = 2'd1;
              w_next     = S_IDLE;
            end
          end else if (w_bad) begin
            w_mark_drop = 1'b1;
            w_next      = S_DRAIN;
          end else begin
            w_next = w_step;
          end
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Word counter, reject flag and header field capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_drop    <= 1'b0;
      r_dst_hi  <= 16'h0;
      r_src_mac <= 48'h0;
      r_is_arp  <= 1'b0;
      r_is_udp  <= 1'b0;
      r_sha     <= 48'h0;
      r_spa     <= 32'h0;
      r_src_ip  <= 32'h0;
      r_w9      <= 32'h0;
      r_w10     <= 32'h0;
    end else if (w_restart) begin
      r_cnt    <= 4'd1;
      r_drop   <= 1'b0;
      r_dst_hi <= i_rx_data[15:0];
    end else if (w_acc && !i_rx_sop && w_in_frame) begin
      if (r_cnt != 4'd11) r_cnt <= r_cnt + 4'd1;
      if (w_mark_drop)    r_drop <= 1'b1;
      case (r_state)
        S_HDR: begin
          if (r_cnt == 4'd2) r_src_mac[47:16] <= i_rx_data;
          if (r_cnt == 4'd3) begin
            r_src_mac[15:0] <= i_rx_data[31:16];
            r_is_arp        <= (i_rx_data[15:0] == 16'h0806);
          end
        end
        S_ARP: begin
          if (r_cnt == 4'd6) r_sha[47:16] <= i_rx_data;
          if (r_cnt == 4'd7) begin
            r_sha[15:0]  <= i_rx_data[31:16];
            r_spa[31:16] <= i_rx_data[15:0];
          end
          if (r_cnt == 4'd8) r_spa[15:0] <= i_rx_data[31:16];
        end
        S_IP: begin
          if (r_cnt == 4'd6) r_is_udp <= (i_rx_data[23:16] == 8'h11);
          if (r_cnt == 4'd7) r_src_ip <= i_rx_data;
        end
        S_L4: begin
          if (r_cnt == 4'd9)  r_w9  <= i_rx_data;
          if (r_cnt == 4'd10) r_w10 <= i_rx_data;
        end
        default: ;
      endcase
    end
  end

  // Report pulses and held result fields, updated only on a reported frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_arp_req      <= 1'b0;
      o_ping_req     <= 1'b0;
      o_udp_vld      <= 1'b0;
      o_arp_sha      <= 48'h0;
      o_arp_spa      <= 32'h0;
      o_icmp_id      <= 16'h0;
      o_icmp_seq     <= 16'h0;
      o_udp_src_port <= 16'h0;
      o_udp_dst_port <= 16'h0;
      o_udp_len      <= 16'h0;
      o_peer_mac     <= 48'h0;
      o_peer_ip      <= 32'h0;
    end else begin
      o_arp_req  <= w_report &  r_is_arp;
      o_ping_req <= w_report & ~r_is_arp & ~r_is_udp;
      o_udp_vld  <= w_report & ~r_is_arp &  r_is_udp;
      if (w_report) begin
        o_peer_mac <= r_src_mac;
        if (r_is_arp) begin
          o_arp_sha <= r_sha;
          o_arp_spa <= r_spa;
          o_peer_ip <= r_spa;
        end else begin
          o_peer_ip <= r_src_ip;
          if (r_is_udp) begin
            o_udp_src_port <= r_w9[31:16];
            o_udp_dst_port <= r_w9[15:0];
            o_udp_len      <= w_w10[31:16];
          end else begin
            o_icmp_id  <= w_w10[31:16];
            o_icmp_seq <= w_w10[15:0];
          end
        end
      end
    end
  end

  // Saturating count of discarded frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      o_drop_cnt <= '0;
    else if (w_drop_sum[DROP_CNT_W]) o_drop_cnt <= '1;
    else                          o_drop_cnt <= w_drop_sum[DROP_CNT_W-1:0];
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_rx_parser
//  Description : Self-checking bench for eth_rx_parser. A frame-level model
//                classifies each complete frame from its word list and is
//                compared with the DUT outputs every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_parser;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] self_mac = 48'h0022_36EC_0401;
  logic [31:0] self_ip  = 32'h0A00_0014;
  logic [31:0] rx_data;
  logic        sop, eop, vld;
  logic        o_rx_rdy, o_arp_req, o_ping_req, o_udp_vld;
  logic [47:0] o_arp_sha, o_peer_mac;
  logic [31:0] o_arp_spa, o_peer_ip;
  logic [15:0] o_icmp_id, o_icmp_seq, o_udp_src_port, o_udp_dst_port, o_udp_len;
  logic [W-1:0] o_drop_cnt;

  int checks = 0;
  int failures = 0;
  int n_arp = 0, n_ping = 0, n_udp = 0;

  // model state
  logic        m_rdy, m_arp, m_ping, m_udp, m_acc;
  logic [47:0] m_sha, m_pmac;
  logic [31:0] m_spa, m_pip;
  logic [15:0] m_id, m_seq, m_sport, m_dport, m_len;
  logic [W-1:0] m_drop;
  logic [31:0] fq[$];
  bit          in_frame;
  logic [31:0] frm[$];

  always #5 clk = ~clk;

  eth_rx_parser #(.DROP_CNT_W(W)) dut (
    .clk(clk), .rst(rst), .i_self_mac(self_mac), .i_self_ip(self_ip),
    .i_rx_data(rx_data), .i_rx_sop(sop), .i_rx_eop(eop), .i_rx_vld(vld),
    .o_rx_rdy(o_rx_rdy), .o_arp_req(o_arp_req), .o_arp_sha(o_arp_sha),
    .o_arp_spa(o_arp_spa), .o_ping_req(o_ping_req), .o_icmp_id(o_icmp_id),
    .o_icmp_seq(o_icmp_seq), .o_udp_vld(o_udp_vld), .o_udp_src_port(o_udp_src_port),
    .o_udp_dst_port(o_udp_dst_port), .o_udp_len(o_udp_len), .o_peer_mac(o_peer_mac),
    .o_peer_ip(o_peer_ip), .o_drop_cnt(o_drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    fq.delete();
    in_frame = 0;
    m_rdy = 1; m_arp = 0; m_ping = 0; m_udp = 0; m_acc = 0;
    m_sha = 0; m_spa = 0; m_id = 0; m_seq = 0; m_sport = 0; m_dport = 0; m_len = 0;
    m_pmac = 0; m_pip = 0; m_drop = 0;
  endfunction

  function automatic void bump_drop();
    if (m_drop != {W{1'b1}}) m_drop = m_drop + 1'b1;
  endfunction

  // Decide the fate of a whole frame from its word list.
  function automatic void classify();
    logic [31:0] w [11];
    logic [47:0] d, s;
    logic [15:0] et;
    logic [7:0]  pr;
    bit ok;
    if (fq.size() < 11) begin
      bump_drop();
      return;
    end
    for (int i = 0; i < 11; i++) w[i] = fq[i];
    d  = {w[0][15:0], w[1]};
    s  = {w[2], w[3][31:16]};
    et = w[3][15:0];
    ok = (d == self_mac) || (d == 48'hFFFF_FFFF_FFFF);
    if (ok && et == 16'h0806) begin
      ok = (w[4] == 32'h0001_0800) && (w[5] == 32'h0604_0001) && (w[10] == self_ip);
      if (ok) begin
        m_arp = 1;
        m_sha = {w[6], w[7][31:16]};
        m_spa = {w[7][15:0], w[8][31:16]};
        m_pip = m_spa;
      end
    end else if (ok && et == 16'h0800) begin
      pr = w[6][23:16];
      ok = (w[4][31:24] == 8'h45) && (pr == 8'h01 || pr == 8'h11) && (w[8] == self_ip) &&
           (pr == 8'h11 || w[9][31:24] == 8'h08);
      if (ok) begin
        m_pip = w[7];
        if (pr == 8'h11) begin
          m_udp = 1; m_sport = w[9][31:16]; m_dport = w[9][15:0]; m_len = w[10][31:16];
        end else begin
          m_ping = 1; m_id = w[10][31:16]; m_seq = w[10][15:0];
        end
      end
    end else begin
      ok = 0;
    end
    if (ok) begin
      m_pmac = s;
      m_rdy  = 0;
    end else begin
      bump_drop();
    end
  endfunction

  function automatic void model_step();
    m_acc = vld && m_rdy;
    m_arp = 0; m_ping = 0; m_udp = 0; m_rdy = 1;
    if (m_acc) begin
      if (sop) begin
        if (in_frame) bump_drop();
        fq.delete();
        fq.push_back(rx_data);
        in_frame = 1;
      end else if (in_frame) begin
        fq.push_back(rx_data);
      end
      if (in_frame && eop) begin
        classify();
        in_frame = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (o_arp_req)  n_arp++;
    if (o_ping_req) n_ping++;
    if (o_udp_vld)  n_udp++;
    chk("rdy", o_rx_rdy, m_rdy);
    chk("arp_req", o_arp_req, m_arp);
    chk("ping_req", o_ping_req, m_ping);
    chk("udp_vld", o_udp_vld, m_udp);
    chk("arp_sha", o_arp_sha, m_sha);
    chk("arp_spa", o_arp_spa, m_spa);
    chk("icmp_id", o_icmp_id, m_id);
    chk("icmp_seq", o_icmp_seq, m_seq);
    chk("udp_src", o_udp_src_port, m_sport);
    chk("udp_dst", o_udp_dst_port, m_dport);
    chk("udp_len", o_udp_len, m_len);
    chk("peer_mac", o_peer_mac, m_pmac);
    chk("peer_ip", o_peer_ip, m_pip);
    chk("drop_cnt", o_drop_cnt, m_drop);
  end

  task automatic idle(input int n);
    vld = 0; sop = 0; eop = 0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    tick(); tick();
    rst = 0;
  endtask

  task automatic send_word(input logic [31:0] d, input bit s, input bit e, input int maxgap);
    int g;
    int waited;
    g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    repeat (g) begin
      vld = 0; rx_data = $urandom; sop = 1'($urandom_range(0, 1)); eop = 1'($urandom_range(0, 1));
      tick();
    end
    vld = 1; rx_data = d; sop = s; eop = e;
    tick();
    waited = 0;
    while (!m_acc) begin
      tick();
      waited++;
      if (waited > 8) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    vld = 0; sop = 0; eop = 0;
  endtask

  task automatic send_frame(input int n_send, input bit with_eop, input int gap);
    for (int i = 0; i < n_send; i++)
      send_word(frm[i], i == 0, with_eop && (i == n_send - 1), gap);
  endtask

  task automatic build_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et);
    frm.delete();
    frm.push_back({16'h0, d[47:32]});
    frm.push_back(d[31:0]);
    frm.push_back(s[47:16]);
    frm.push_back({s[15:0], et});
  endtask

  task automatic build_arp(input logic [47:0] d, input logic [47:0] s, input logic [47:0] sha,
                           input logic [31:0] spa, input logic [31:0] tpa, input int n);
    build_hdr(d, s, 16'h0806);
    frm.push_back(32'h0001_0800);
    frm.push_back(32'h0604_0001);
    frm.push_back(sha[47:16]);
    frm.push_back({sha[15:0], spa[31:16]});
    frm.push_back({spa[15:0], 16'h0});
    frm.push_back(32'h0);
    frm.push_back(tpa);
    while (frm.size() < n) frm.push_back($urandom);
  endtask

  task automatic build_ip(input logic [47:0] d, input logic [47:0] s, input logic [7:0] pr,
                          input logic [31:0] sip, input logic [31:0] dip,
                          input logic [31:0] w9, input logic [31:0] w10, input int n);
    build_hdr(d, s, 16'h0800);
    frm.push_back({8'h45, 8'h00, 16'(4 * (n - 4))});
    frm.push_back($urandom);
    frm.push_back({8'h40, pr, 16'($urandom)});
    frm.push_back(sip);
    frm.push_back(dip);
    frm.push_back(w9);
    frm.push_back(w10);
    while (frm.size() < n) frm.push_back($urandom);
  endtask

  initial begin
    int a0, p0, u0, n, k, c, kind;
    logic [47:0] dmac, smac;
    logic [31:0] mask;
    rst = 1; vld = 0; sop = 0; eop = 0; rx_data = 0;
    model_reset();
    tick(); tick(); tick();
    rst = 0;
    chk("reset_rdy", o_rx_rdy, 1);
    chk("reset_drop", o_drop_cnt, 0);
    chk("reset_peer_ip", o_peer_ip, 0);
    idle(2);

    // Broadcast ARP request, eop on word10
    a0 = n_arp;
    build_arp(48'hFFFF_FFFF_FFFF, 48'h3CF0_11B2_523C, 48'h3CF0_11B2_523C, 32'hC0A8_012E, 32'h0A00_0014, 11);
    send_frame(11, 1, 0);
    chk("arp_pulse_latency", o_arp_req, 1);
    chk("arp_rdy_low", o_rx_rdy, 0);
    chk("arp_sha_lit", o_arp_sha, 48'h3CF0_11B2_523C);
    chk("arp_spa_lit", o_arp_spa, 32'hC0A8_012E);
    idle(3);
    chk("arp_pulse_once", n_arp - a0, 1);

    // Ping, 25 words
    p0 = n_ping;
    build_ip(48'h0022_36EC_0401, 48'h0011_2233_4455, 8'h01, 32'h0A00_0016, 32'h0A00_0014,
             32'h0800_1234, 32'h1486_45C1, 25);
    send_frame(25, 1, 0);
    chk("ping_pulse_latency", o_ping_req, 1);
    idle(2);
    chk("ping_pulse_once", n_ping - p0, 1);
    chk("ping_peer_ip_lit", o_peer_ip, 32'h0A00_0016);
    chk("ping_id_lit", o_icmp_id, 16'h1486);
    chk("ping_seq_lit", o_icmp_seq, 16'h45C1);

    // UDP, 43 words with valid gaps
    u0 = n_udp;
    build_ip(48'hFFFF_FFFF_FFFF, 48'h0A0B_0C0D_0E0F, 8'h11, 32'h0A00_0063, 32'h0A00_0014,
             32'h1122_5152, 32'h0088_14C3, 43);
    send_frame(43, 1, 3);
    idle(2);
    chk("udp_pulse_once", n_udp - u0, 1);
    chk("udp_src_lit", o_udp_src_port, 16'h1122);
    chk("udp_dst_lit", o_udp_dst_port, 16'h5152);
    chk("udp_len_lit", o_udp_len, 16'h0088);

    // ARP truncated at word7, then a good ARP
    do_reset();
    a0 = n_arp;
    build_arp(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0042, 48'h0000_0000_0042, 32'h0A00_0001, 32'h0A00_0014, 11);
    send_frame(8, 1, 0);
    idle(2);
    chk("trunc_drop_lit", o_drop_cnt, 1);
    chk("trunc_no_pulse", n_arp - a0, 0);
    send_frame(11, 1, 0);
    idle(2);
    chk("arp_after_trunc", n_arp - a0, 1);

    // Ping aborted at word5 by a new ARP sop
    a0 = n_arp; p0 = n_ping;
    build_ip(48'h0022_36EC_0401, 48'h0011_2233_4455, 8'h01, 32'h0A00_0016, 32'h0A00_0014,
             32'h0800_0000, 32'h0001_0002, 14);
    send_frame(5, 0, 0);
    build_arp(48'h0022_36EC_0401, 48'h00AA_BBCC_DDEE, 48'h00AA_BBCC_DDEE, 32'h0A00_0033, 32'h0A00_0014, 12);
    send_frame(12, 1, 0);
    idle(2);
    chk("abort_drop_lit", o_drop_cnt, 2);
    chk("abort_arp_once", n_arp - a0, 1);
    chk("abort_no_ping", n_ping - p0, 0);

    // Reset in the middle of a UDP frame
    u0 = n_udp;
    build_ip(48'h0022_36EC_0401, 48'h0011_2233_4455, 8'h11, 32'h0A00_0077, 32'h0A00_0014,
             32'h0035_0400, 32'h0020_0000, 16);
    send_frame(7, 0, 1);
    do_reset();
    chk("midrst_drop_lit", o_drop_cnt, 0);
    chk("midrst_peer_mac_lit", o_peer_mac, 0);
    chk("midrst_sha_lit", o_arp_sha, 0);
    for (int i = 7; i < 16; i++) send_word(frm[i], 0, i == 15, 0);
    idle(2);
    chk("midrst_no_pulse", n_udp - u0, 0);
    send_frame(16, 1, 0);
    idle(2);
    chk("after_rst_udp", n_udp - u0, 1);
    chk("after_rst_len_lit", o_udp_len, 16'h0020);

    // Randomized traffic
    for (int f = 0; f < 80; f++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(11, 20);
      c    = $urandom_range(0, 3);
      dmac = (c == 0) ? 48'h0022_36EC_0402 : (c == 1) ? 48'hFFFF_FFFF_FFFF : self_mac;
      smac = {$urandom, $urandom};
      if (kind == 0)
        build_arp(dmac, smac, smac, $urandom, self_ip, n);
      else if (kind == 1)
        build_ip(dmac, smac, 8'h01, $urandom, self_ip, {8'h08, 8'h00, 16'($urandom)}, $urandom, n);
      else
        build_ip(dmac, smac, 8'h11, $urandom, self_ip, $urandom, $urandom, n);
      c = $urandom_range(0, 11);
      if (c == 0 || c == 1) begin
        k = $urandom_range(1, 10);
        mask = 32'h1 << $urandom_range(0, 31);
        frm[k] = frm[k] ^ mask;
      end
      if (c == 2) send_word($urandom, 0, 1'($urandom_range(0, 1)), 0);
      if (c == 3) begin
        send_frame($urandom_range(1, n), 1, $urandom_range(0, 2));
      end else if (c == 4) begin
        send_frame($urandom_range(1, n), 0, $urandom_range(0, 2));
      end else begin
        send_frame(n, 1, $urandom_range(0, 2));
      end
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
